gemm_fifo_bank: RTL and testbench
=================================

// Module: gemm_fifo_bank
// PURPOSE
//  Four-lane buffer stage directly upstream of the GEMM sequencing FSM.
//  Accepts gemmFIFO_t entries on a single write port from the scratchpad load path, steered by lane select.
//  Holds them in four independent first-word-fall-through FIFOs.
//  Presents per-lane rdata/empty to the FSM, which pops a lane by pulsing gemmFIFOn_REN.
//  Drives the aggregate fifo_has_space flag back to the load path.
// PARAMETERS
//  DEPTH      8   entries per lane; power of two, >=2
//  CNT_W      $clog2(DEPTH)+1   occupancy counter width (derived, localparam)
// PORTS
//  CLK               in   1        clock
//  nRST              in   1        reset, synchronous, active-low
//  flush             in   1        synchronous clear of all four lanes
//  wen               in   1        write strobe from load path
//  wsel              in   2        target lane 0..3
//  wdata             in   gemmFIFO_t  entry to enqueue
//  gemmFIFO0_REN..3  in   1 each   pop strobe per lane, from FSM
//  gemmFIFO0_rdata..3 out gemmFIFO_t  head entry of each lane (FWFT)
//  gemmFIFO0_empty..3 out 1 each   lane has no valid entry
//  lane_full         out  4        per-lane full, bit n = lane n
//  fifo_has_space    out  1        all four lanes below DEPTH
//  overflow_err      out  1        sticky: write attempted to full lane
//  underflow_err     out  1        sticky: REN seen on empty lane
// BEHAVIOUR
//  Reset (nRST=0 at posedge), from the following cycle:
//   - All pointers and counts 0.
//   - empty=1111, lane_full=0, fifo_has_space=1, both err=0.
//   - rdata is don't-care while empty; implementation drives 0.
//  Flush: same effect as reset on pointers/counts; does NOT clear the sticky errors. Flush wins over same-cycle wen/REN.
//  Write:
//   - wen=1 and lane[wsel] not full -> entry stored at wptr; wptr+1 mod DEPTH; count+1.
//   - Entry is visible on rdata with empty=0 the next cycle (1-cycle latency, no same-cycle bypass).
//  Read:
//   - rdata = mem[rptr] combinationally.
//   - REN=1 and lane not empty -> rptr+1 mod DEPTH; count-1. The next entry appears the following cycle.
//  Simultaneous write+pop, same lane:
//   - Not full and not empty: both occur, count unchanged.
//   - Full: the pop frees a slot, so the write is accepted and the count stays DEPTH.
//   - Empty: the write is accepted, the pop is ignored and flags underflow.
//  Illegal events:
//   - Write to a full lane (without a same-lane pop): data dropped, pointers unchanged, overflow_err<=1 until reset.
//   - REN on an empty lane: no pointer change, underflow_err<=1 until reset.
//  Multiple lanes may be popped in one cycle; only one lane is written per cycle.
//  Pointers wrap modulo DEPTH. full = (count==DEPTH). empty = (count==0).
//  fifo_has_space = ~|lane_full, registered-state derived (combinational from counts, no lookahead).
// CONFIGURATION
//  GEMM_FIFO_BANK_HWM_EN defined:
//   - Adds output hwm[4*CNT_W-1:0], the per-lane high-water mark of count.
//   - Updated each cycle as max(hwm, count). Cleared by reset only, not by flush.
//  Not defined: the port and its registers are absent; all other behaviour is identical.
// STRUCTURE
//  sp_types_pkg already holds gemmFIFO_t. This block adds to it:
//   - GEMM_LANES=4 constant.
//   - typedef logic [1:0] gemm_lane_t for wsel.
//  Sub-module sp_sync_fifo (one lane; generic DEPTH/type; flush, wen, ren, rdata, empty, full, count, ovf/udf pulses).
//  Instantiated 4x in a generate loop. The top level decodes wsel, maps the lanes onto the named ports and ORs the errors into sticky regs.
// TESTING
//  1. Reset -> empty=1111, lane_full=0, fifo_has_space=1, errs=0.
//     Pulse REN0 while empty -> underflow_err=1, count stays 0.
//  2. Write A,B,C to lane 2 (wsel=2, back to back).
//     -> cycle after A: empty2=0, rdata2=A.
//     -> Pop thrice: rdata2 = B then C, then empty2=1. Lanes 0,1,3 untouched.
//  3. Fill lane 1 with 8 entries -> lane_full=0010, fifo_has_space=0.
//     9th write -> dropped, overflow_err=1.
//     Pop -> 1st entry out, fifo_has_space=1 next cycle.
//  4. Lane 3 full plus wen(wsel=3)+REN3 same cycle -> write accepted, count stays 8.
//     Drain 8 -> order intact incl. new entry last.
//  5. Wrap: 20 interleaved write/pop pairs on lane 0 with DEPTH=8 -> FIFO order preserved across pointer wrap.
//  6. Flush with 3 entries in lanes 0 and 2 plus concurrent wen -> next cycle all empty, the write is lost, the sticky errors retain their prior values.
//     With GEMM_FIFO_BANK_HWM_EN: hwm lane0 still 3.

Source files
------------

// File: rtl/gemm_fifo_bank_pkg.sv
// Shared types for the GEMM lane buffer.
//   gemmFIFO_t  : one queued GEMM work entry
//   GEMM_LANES  : number of independent lanes in the bank
//   gemm_lane_t : lane index carried on the write-select bus
//   cnt_width() : occupancy counter width for a given lane depth
package gemm_fifo_bank_pkg;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
  } gemmFIFO_t;

  localparam int GEMM_LANES = 4;

  typedef logic [1:0] gemm_lane_t;

  // The counter must reach DEPTH itself, hence one bit more than the pointer.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gemm_fifo_bank_if.sv
// Bus bundle between the scratchpad load path / GEMM sequencer and the lane bank.
//   slave  : the bank (consumes write/pop/flush, produces head data and status)
//   master : the surrounding logic driving the bank
// Signals:
//   flush, wen, wsel, wdata          -> bank
//   gemmFIFOn_REN (n=0..3)           -> bank
//   gemmFIFOn_rdata, gemmFIFOn_empty <- bank
//   lane_full, fifo_has_space        <- bank
//   overflow_err, underflow_err      <- bank
//   hwm (GEMM_FIFO_BANK_HWM_EN only) <- bank
interface gemm_fifo_bank_if #(
  parameter int DEPTH = 8
);
  import gemm_fifo_bank_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic       flush;
  logic       wen;
  gemm_lane_t wsel;
  gemmFIFO_t  wdata;

  logic gemmFIFO0_REN;
  logic gemmFIFO1_REN;
  logic gemmFIFO2_REN;
  logic gemmFIFO3_REN;

  gemmFIFO_t gemmFIFO0_rdata;
  gemmFIFO_t gemmFIFO1_rdata;
  gemmFIFO_t gemmFIFO2_rdata;
  gemmFIFO_t gemmFIFO3_rdata;

  logic gemmFIFO0_empty;
  logic gemmFIFO1_empty;
  logic gemmFIFO2_empty;
  logic gemmFIFO3_empty;

  logic [GEMM_LANES-1:0] lane_full;
  logic                  fifo_has_space;
  logic                  overflow_err;
  logic                  underflow_err;

`ifdef GEMM_FIFO_BANK_HWM_EN
  logic [GEMM_LANES*CNT_W-1:0] hwm;
`endif

  modport slave (
    input  flush, wen, wsel, wdata,
    input  gemmFIFO0_REN, gemmFIFO1_REN, gemmFIFO2_REN, gemmFIFO3_REN,
    output gemmFIFO0_rdata, gemmFIFO1_rdata, gemmFIFO2_rdata, gemmFIFO3_rdata,
    output gemmFIFO0_empty, gemmFIFO1_empty, gemmFIFO2_empty, gemmFIFO3_empty,
`ifdef GEMM_FIFO_BANK_HWM_EN
    output hwm,
`endif
    output lane_full, fifo_has_space, overflow_err, underflow_err
  );

  modport master (
    output flush, wen, wsel, wdata,
    output gemmFIFO0_REN, gemmFIFO1_REN, gemmFIFO2_REN, gemmFIFO3_REN,
    input  gemmFIFO0_rdata, gemmFIFO1_rdata, gemmFIFO2_rdata, gemmFIFO3_rdata,
    input  gemmFIFO0_empty, gemmFIFO1_empty, gemmFIFO2_empty, gemmFIFO3_empty,
`ifdef GEMM_FIFO_BANK_HWM_EN
    input  hwm,
`endif
    input  lane_full, fifo_has_space, overflow_err, underflow_err
  );

endinterface

// File: rtl/gemm_fifo_bank_sync_fifo.sv
// sp_sync_fifo: one first-word-fall-through lane of the GEMM buffer bank.
// Ports:
//   CLK, nRST : clock, synchronous active-low reset
//   flush     : synchronous clear of pointers/count; overrides wen/ren
//   wen/wdata : enqueue request and entry
//   ren       : pop request
//   rdata     : head entry (0 while empty)
//   empty/full/count : occupancy status
//   ovf/udf   : single-cycle pulses for a dropped write / ignored pop
module sp_sync_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0],
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             wen,
  input  logic             ren,
  input  T                 wdata,
  output T                 rdata,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             udf
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign count = cnt;

  // A pop on a full lane frees the head slot in the same edge, so the
  // write goes into the slot being vacated (wptr == rptr when full).
  assign do_pop  = ren & ~empty & ~flush;
  assign do_push = wen & (~full | ren) & ~flush;
  assign ovf     = wen & full & ~ren & ~flush;
  assign udf     = ren & empty & ~flush;

  assign rdata = empty ? T'('0) : mem[rptr];

  always_ff @(posedge CLK) begin
    if (!nRST || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/gemm_fifo_bank.sv
// gemm_fifo_bank: four-lane FWFT buffer between the scratchpad load path and
// the GEMM sequencing FSM.
// Ports:
//   CLK  : clock
//   nRST : synchronous active-low reset
//   bus  : gemm_fifo_bank_if.slave (write port, per-lane pops, per-lane head
//          data/empty, lane_full, fifo_has_space, sticky overflow/underflow)
// Build option: GEMM_FIFO_BANK_HWM_EN adds bus.hwm, per-lane high-water mark
// of occupancy, cleared by reset only.
module gemm_fifo_bank
  import gemm_fifo_bank_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  gemm_fifo_bank_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [GEMM_LANES-1:0] ren;
  logic [GEMM_LANES-1:0] wen_lane;
  logic [GEMM_LANES-1:0] empty;
  logic [GEMM_LANES-1:0] full;
  logic [GEMM_LANES-1:0] ovf;
  logic [GEMM_LANES-1:0] udf;
  gemmFIFO_t             rdata [GEMM_LANES];
  logic [CNT_W-1:0]      count [GEMM_LANES];
  logic                  ovf_sticky;
  logic                  udf_sticky;

  assign ren = {bus.gemmFIFO3_REN, bus.gemmFIFO2_REN,
                bus.gemmFIFO1_REN, bus.gemmFIFO0_REN};

  for (genvar i = 0; i < GEMM_LANES; i++) begin : g_lane
    assign wen_lane[i] = bus.wen && (bus.wsel == gemm_lane_t'(i));

    sp_sync_fifo #(
      .DEPTH (DEPTH),
      .T     (gemmFIFO_t)
    ) u_fifo (
      .CLK   (CLK),
      .nRST  (nRST),
      .flush (bus.flush),
      .wen   (wen_lane[i]),
      .ren   (ren[i]),
      .wdata (bus.wdata),
      .rdata (rdata[i]),
      .empty (empty[i]),
      .full  (full[i]),
      .count (count[i]),
      .ovf   (ovf[i]),
      .udf   (udf[i])
    );
  end

  assign bus.gemmFIFO0_rdata = rdata[0];
  assign bus.gemmFIFO1_rdata = rdata[1];
  assign bus.gemmFIFO2_rdata = rdata[2];
  assign bus.gemmFIFO3_rdata = rdata[3];

  assign bus.gemmFIFO0_empty = empty[0];
  assign bus.gemmFIFO1_empty = empty[1];
  assign bus.gemmFIFO2_empty = empty[2];
  assign bus.gemmFIFO3_empty = empty[3];

  assign bus.lane_full      = full;
  assign bus.fifo_has_space = ~|full;

  // Error flags survive flush; only reset clears them.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      if (|ovf) ovf_sticky <= 1'b1;
      if (|udf) udf_sticky <= 1'b1;
    end
  end

  assign bus.overflow_err  = ovf_sticky;
  assign bus.underflow_err = udf_sticky;

`ifdef GEMM_FIFO_BANK_HWM_EN
  logic [CNT_W-1:0] hwm [GEMM_LANES];

  // Tracks the registered count, so a new peak shows one cycle after it occurs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < GEMM_LANES; i++) hwm[i] <= '0;
    end else begin
      for (int i = 0; i < GEMM_LANES; i++) begin
        if (count[i] > hwm[i]) hwm[i] <= count[i];
      end
    end
  end

  assign bus.hwm = {hwm[3], hwm[2], hwm[1], hwm[0]};
`else
  // Lane counts only feed the high-water marks.
  logic unused_count;
  assign unused_count = ^{count[0], count[1], count[2], count[3]};
`endif

endmodule

// File: tb/tb_gemm_fifo_bank.sv
// Self-checking bench for gemm_fifo_bank: directed scenarios followed by
// random traffic, all compared against a queue-based lane model.
module tb_gemm_fifo_bank;
  import gemm_fifo_bank_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  gemm_fifo_bank_if #(.DEPTH(DEPTH)) bus ();

  gemm_fifo_bank #(.DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  gemmFIFO_t mq [4][$];
  bit        m_ovf;
  bit        m_udf;
  int        m_hwm [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic gemmFIFO_t mk(input int t, input int d);
    gemmFIFO_t e;
    e.tag  = 4'(t);
    e.data = 32'(d);
    return e;
  endfunction

  function automatic gemmFIFO_t dut_rdata(input int l);
    case (l)
      0:       return bus.gemmFIFO0_rdata;
      1:       return bus.gemmFIFO1_rdata;
      2:       return bus.gemmFIFO2_rdata;
      default: return bus.gemmFIFO3_rdata;
    endcase
  endfunction

  function automatic logic dut_empty(input int l);
    case (l)
      0:       return bus.gemmFIFO0_empty;
      1:       return bus.gemmFIFO1_empty;
      2:       return bus.gemmFIFO2_empty;
      default: return bus.gemmFIFO3_empty;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.flush = 1'b0;
    bus.wen   = 1'b0;
    bus.wsel  = '0;
    bus.wdata = '0;
    bus.gemmFIFO0_REN = 1'b0;
    bus.gemmFIFO1_REN = 1'b0;
    bus.gemmFIFO2_REN = 1'b0;
    bus.gemmFIFO3_REN = 1'b0;
  endtask

  task automatic check_all(input string tag);
    gemmFIFO_t head;
    for (int l = 0; l < 4; l++) begin
      head = (mq[l].size() > 0) ? mq[l][0] : gemmFIFO_t'('0);
      chk($sformatf("%s empty%0d", tag, l), 64'(dut_empty(l)), 64'(mq[l].size() == 0));
      chk($sformatf("%s rdata%0d", tag, l), 64'(dut_rdata(l)), 64'(head));
      chk($sformatf("%s full%0d", tag, l), 64'(bus.lane_full[l]), 64'(mq[l].size() == DEPTH));
`ifdef GEMM_FIFO_BANK_HWM_EN
      chk($sformatf("%s hwm%0d", tag, l), 64'(bus.hwm[l*CNT_W +: CNT_W]), 64'(m_hwm[l]));
`endif
    end
    chk({tag, " space"}, 64'(bus.fifo_has_space),
        64'(mq[0].size() < DEPTH && mq[1].size() < DEPTH &&
            mq[2].size() < DEPTH && mq[3].size() < DEPTH));
    chk({tag, " ovf"}, 64'(bus.overflow_err), 64'(m_ovf));
    chk({tag, " udf"}, 64'(bus.underflow_err), 64'(m_udf));
  endtask

  // One clock: drive inputs, advance the model, sample after the edge.
  task automatic cycle(input string tag, input logic fl, input logic w, input int sel,
                       input gemmFIFO_t d, input logic [3:0] r);
    int sz [4];
    bus.flush = fl;
    bus.wen   = w;
    bus.wsel  = gemm_lane_t'(sel);
    bus.wdata = d;
    bus.gemmFIFO0_REN = r[0];
    bus.gemmFIFO1_REN = r[1];
    bus.gemmFIFO2_REN = r[2];
    bus.gemmFIFO3_REN = r[3];

    for (int l = 0; l < 4; l++) begin
      sz[l] = mq[l].size();
      if (sz[l] > m_hwm[l]) m_hwm[l] = sz[l];
    end
    if (fl) begin
      for (int l = 0; l < 4; l++) mq[l].delete();
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (r[l]) begin
          if (sz[l] > 0) void'(mq[l].pop_front());
          else           m_udf = 1'b1;
        end
      end
      if (w) begin
        if (sz[sel] < DEPTH || r[sel]) mq[sel].push_back(d);
        else                            m_ovf = 1'b1;
      end
    end

    @(posedge CLK);
    #1;
    idle_inputs();
    check_all(tag);
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    for (int l = 0; l < 4; l++) begin
      mq[l].delete();
      m_hwm[l] = 0;
    end
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    gemmFIFO_t nul;
    nul = '0;
    idle_inputs();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // Reset state
    check_all("rst");
    chk("rst empties", 64'({bus.gemmFIFO3_empty, bus.gemmFIFO2_empty,
                             bus.gemmFIFO1_empty, bus.gemmFIFO0_empty}), 64'hF);
    chk("rst lane_full", 64'(bus.lane_full), 64'h0);
    chk("rst space", 64'(bus.fifo_has_space), 64'h1);
    cycle("udf0", 1'b0, 1'b0, 0, nul, 4'b0001);
    chk("udf0 err", 64'(bus.underflow_err), 64'h1);
    chk("udf0 empty0", 64'(bus.gemmFIFO0_empty), 64'h1);

    // Lane 2 ordering
    cycle("l2 wA", 1'b0, 1'b1, 2, mk(1, 'hA), 4'b0000);
    chk("l2 A empty2", 64'(bus.gemmFIFO2_empty), 64'h0);
    chk("l2 A rdata2", 64'(bus.gemmFIFO2_rdata), 64'(mk(1, 'hA)));
    cycle("l2 wB", 1'b0, 1'b1, 2, mk(2, 'hB), 4'b0000);
    cycle("l2 wC", 1'b0, 1'b1, 2, mk(3, 'hC), 4'b0000);
    cycle("l2 p1", 1'b0, 1'b0, 0, nul, 4'b0100);
    chk("l2 B rdata2", 64'(bus.gemmFIFO2_rdata), 64'(mk(2, 'hB)));
    cycle("l2 p2", 1'b0, 1'b0, 0, nul, 4'b0100);
    chk("l2 C rdata2", 64'(bus.gemmFIFO2_rdata), 64'(mk(3, 'hC)));
    cycle("l2 p3", 1'b0, 1'b0, 0, nul, 4'b0100);
    chk("l2 drained", 64'(bus.gemmFIFO2_empty), 64'h1);

    // Lane 1 full / overflow
    for (int i = 0; i < DEPTH; i++)
      cycle("l1 fill", 1'b0, 1'b1, 1, mk(4, 'h100 + i), 4'b0000);
    chk("l1 lane_full", 64'(bus.lane_full), 64'h2);
    chk("l1 nospace", 64'(bus.fifo_has_space), 64'h0);
    cycle("l1 w9", 1'b0, 1'b1, 1, mk(5, 'h1FF), 4'b0000);
    chk("l1 ovf", 64'(bus.overflow_err), 64'h1);
    chk("l1 head", 64'(bus.gemmFIFO1_rdata), 64'(mk(4, 'h100)));
    cycle("l1 pop", 1'b0, 1'b0, 0, nul, 4'b0010);
    chk("l1 space back", 64'(bus.fifo_has_space), 64'h1);

    // Lane 3 full with simultaneous write and pop
    for (int i = 0; i < DEPTH; i++)
      cycle("l3 fill", 1'b0, 1'b1, 3, mk(6, 'h300 + i), 4'b0000);
    cycle("l3 wr+pop", 1'b0, 1'b1, 3, mk(7, 'h3AA), 4'b1000);
    chk("l3 still full", 64'(bus.lane_full[3]), 64'h1);
    for (int i = 0; i < DEPTH; i++) cycle("l3 drain", 1'b0, 1'b0, 0, nul, 4'b1000);

    // Lane 0 pointer wrap
    for (int i = 0; i < 20; i++) begin
      cycle("l0 wrap w", 1'b0, 1'b1, 0, mk(8, 'h400 + i), 4'b0000);
      chk("l0 wrap head", 64'(bus.gemmFIFO0_rdata), 64'(mk(8, 'h400 + i)));
      cycle("l0 wrap p", 1'b0, 1'b0, 0, nul, 4'b0001);
    end

    // Flush with concurrent write
    for (int i = 0; i < 3; i++) begin
      cycle("fl w0", 1'b0, 1'b1, 0, mk(9, 'h500 + i), 4'b0000);
      cycle("fl w2", 1'b0, 1'b1, 2, mk(10, 'h600 + i), 4'b0000);
    end
    cycle("flush", 1'b1, 1'b1, 0, mk(11, 'h777), 4'b0101);
    chk("flush empty0", 64'(bus.gemmFIFO0_empty), 64'h1);
    chk("flush ovf kept", 64'(bus.overflow_err), 64'h1);
    chk("flush udf kept", 64'(bus.underflow_err), 64'h1);
`ifdef GEMM_FIFO_BANK_HWM_EN
    chk("flush hwm0", 64'(bus.hwm[CNT_W-1:0]), 64'd3);
`endif

    // Random traffic with varying pop pressure
    do_reset();
    check_all("rnd rst");
    for (int blk = 0; blk < 12; blk++) begin
      int pop_pct;
      pop_pct = 10 + 15 * (blk % 5);
      if (blk == 6) do_reset();
      for (int i = 0; i < 200; i++) begin
        logic [3:0] r;
        for (int l = 0; l < 4; l++) r[l] = ($urandom_range(99) < pop_pct);
        cycle("rnd", ($urandom_range(99) == 0), ($urandom_range(99) < 60),
              int'($urandom_range(3)), mk(int'($urandom_range(15)), int'($urandom)), r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
